// File: rtl/sort_pkg.sv
// Shared types and constants for the sequential weight sorter.
//   state_t   : controller states (IDLE, SORT, DONE)
//   SORT_DESC : mode value selecting descending weight order
//   SORT_ASC  : mode value selecting ascending weight order
package sort_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic SORT_DESC = 1'b0;
   localparam logic SORT_ASC  = 1'b1;

endpackage

// File: rtl/sort_seq_ip_if.sv
// Bundle-in / sorted-bundle-out handshake bus for sort_seq_ip.
//   in_valid/in_ready       : input bundle handshake
//   in_mode                 : 0 descending, 1 ascending
//   in_character, in_weight : N packed elements, element i at [i*W +: W]
//   out_valid/out_ready     : result handshake
//   out_character/weight    : N packed slots, slot 0 in the MSB field
interface sort_seq_ip_if #(
   parameter int unsigned N        = 8,
   parameter int unsigned CHAR_W   = 4,
   parameter int unsigned WEIGHT_W = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_mode;
   logic [N*CHAR_W-1:0]   in_character;
   logic [N*WEIGHT_W-1:0] in_weight;
   logic                  out_valid;
   logic                  out_ready;
   logic [N*CHAR_W-1:0]   out_character;
   logic [N*WEIGHT_W-1:0] out_weight;

   modport master (
      output in_valid, in_mode, in_character, in_weight, out_ready,
      input  in_ready, out_valid, out_character, out_weight
   );

   modport slave (
      input  in_valid, in_mode, in_character, in_weight, out_ready,
      output in_ready, out_valid, out_character, out_weight
   );
endinterface

// File: rtl/sort_cas.sv
// Compare-exchange cell: orders one adjacent slot pair by weight.
//   mode                 : SORT_DESC or SORT_ASC
//   a_* / b_*            : lower slot (s) and upper slot (s+1) inputs
//   lo_*_c / hi_*_c      : values for slot s and slot s+1 after exchange
// Swaps only on strict disorder, which keeps the network stable.
module sort_cas
   import sort_pkg::*;
#(
   parameter int unsigned CHAR_W   = 4,
   parameter int unsigned WEIGHT_W = 5
) (
   input  logic                mode,
   input  logic [CHAR_W-1:0]   a_char,
   input  logic [WEIGHT_W-1:0] a_weight,
   input  logic [CHAR_W-1:0]   b_char,
   input  logic [WEIGHT_W-1:0] b_weight,
   output logic [CHAR_W-1:0]   lo_char_c,
   output logic [WEIGHT_W-1:0] lo_weight_c,
   output logic [CHAR_W-1:0]   hi_char_c,
   output logic [WEIGHT_W-1:0] hi_weight_c
);
   logic swap_c;

   always_comb begin
      swap_c = (mode == SORT_ASC) ? (a_weight > b_weight) : (a_weight < b_weight);
   end

   assign lo_char_c   = swap_c ? b_char   : a_char;
   assign lo_weight_c = swap_c ? b_weight : a_weight;
   assign hi_char_c   = swap_c ? a_char   : b_char;
   assign hi_weight_c = swap_c ? a_weight : b_weight;
endmodule

// File: rtl/sort_seq_ip.sv
// Sequential odd-even transposition sorter, one phase per clock.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : sort_seq_ip_if slave (bundle in, sorted bundle out)
// Slot s is loaded from element N-1-s, so the output packing matches
// the input packing until phases reorder it.
module sort_seq_ip
   import sort_pkg::*;
#(
   parameter int unsigned N        = 8,
   parameter int unsigned CHAR_W   = 4,
   parameter int unsigned WEIGHT_W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   sort_seq_ip_if.slave bus
);
   localparam int unsigned PHASE_W = $clog2(N) + 1;
   localparam int unsigned N_EVEN  = N / 2;
   localparam int unsigned N_ODD   = (N - 1) / 2;

   state_t               state, state_d;
   logic [PHASE_W-1:0]   phase;
   logic                 mode;
   logic [CHAR_W-1:0]    slot_char   [N];
   logic [WEIGHT_W-1:0]  slot_weight [N];
   logic [CHAR_W-1:0]    ev_char     [N];
   logic [WEIGHT_W-1:0]  ev_weight   [N];
   logic [CHAR_W-1:0]    od_char     [N];
   logic [WEIGHT_W-1:0]  od_weight   [N];
   logic                 accept_c;
   logic                 last_phase_c;

   assign accept_c     = (state == IDLE) && bus.in_valid;
   assign last_phase_c = (phase == PHASE_W'(N - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_d = SORT;
         SORT:    if (last_phase_c)  state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Even-phase network: pairs (0,1), (2,3), ...; odd N leaves the top slot alone
   for (genvar k = 0; k < N_EVEN; k++) begin : g_even
      sort_cas #(.CHAR_W(CHAR_W), .WEIGHT_W(WEIGHT_W)) u_cas (
         .mode        (mode),
         .a_char      (slot_char[2*k]),
         .a_weight    (slot_weight[2*k]),
         .b_char      (slot_char[2*k+1]),
         .b_weight    (slot_weight[2*k+1]),
         .lo_char_c   (ev_char[2*k]),
         .lo_weight_c (ev_weight[2*k]),
         .hi_char_c   (ev_char[2*k+1]),
         .hi_weight_c (ev_weight[2*k+1])
      );
   end
   if (N % 2 == 1) begin : g_even_tail
      assign ev_char[N-1]   = slot_char[N-1];
      assign ev_weight[N-1] = slot_weight[N-1];
   end

   // Odd-phase network: pairs (1,2), (3,4), ...; slot 0 always holds
   assign od_char[0]   = slot_char[0];
   assign od_weight[0] = slot_weight[0];
   for (genvar k = 0; k < N_ODD; k++) begin : g_odd
      sort_cas #(.CHAR_W(CHAR_W), .WEIGHT_W(WEIGHT_W)) u_cas (
         .mode        (mode),
         .a_char      (slot_char[2*k+1]),
         .a_weight    (slot_weight[2*k+1]),
         .b_char      (slot_char[2*k+2]),
         .b_weight    (slot_weight[2*k+2]),
         .lo_char_c   (od_char[2*k+1]),
         .lo_weight_c (od_weight[2*k+1]),
         .hi_char_c   (od_char[2*k+2]),
         .hi_weight_c (od_weight[2*k+2])
      );
   end
   if (N % 2 == 0) begin : g_odd_tail
      assign od_char[N-1]   = slot_char[N-1];
      assign od_weight[N-1] = slot_weight[N-1];
   end

   // Slot registers, latched mode and phase counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= '0;
         mode  <= SORT_DESC;
         for (int unsigned s = 0; s < N; s++) begin
            slot_char[s]   <= '0;
            slot_weight[s] <= '0;
         end
      end else if (accept_c) begin
         phase <= '0;
         mode  <= bus.in_mode;
         for (int unsigned s = 0; s < N; s++) begin
            slot_char[s]   <= bus.in_character[(N-1-s)*CHAR_W +: CHAR_W];
            slot_weight[s] <= bus.in_weight[(N-1-s)*WEIGHT_W +: WEIGHT_W];
         end
      end else if (state == SORT) begin
         phase <= phase + PHASE_W'(1);
         for (int unsigned s = 0; s < N; s++) begin
            slot_char[s]   <= phase[0] ? od_char[s]   : ev_char[s];
            slot_weight[s] <= phase[0] ? od_weight[s] : ev_weight[s];
         end
      end
   end

   // Outputs come straight from registers
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   for (genvar s = 0; s < N; s++) begin : g_out
      assign bus.out_character[(N-1-s)*CHAR_W +: CHAR_W]     = slot_char[s];
      assign bus.out_weight[(N-1-s)*WEIGHT_W +: WEIGHT_W]    = slot_weight[s];
   end
endmodule

// File: tb/tb_sort_seq_ip.sv
// Self-checking bench for sort_seq_ip: an N=8 and an N=3 instance,
// directed cases plus random bundles against a stable insertion-sort model.
module tb_sort_seq_ip;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   sort_seq_ip_if #(.N(8), .CHAR_W(4), .WEIGHT_W(5)) bus8 ();
   sort_seq_ip_if #(.N(3), .CHAR_W(4), .WEIGHT_W(5)) bus3 ();

   sort_seq_ip #(.N(8), .CHAR_W(4), .WEIGHT_W(5)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   sort_seq_ip #(.N(3), .CHAR_W(4), .WEIGHT_W(5)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic obs_valid(input int n);
      return (n == 8) ? bus8.out_valid : bus3.out_valid;
   endfunction
   function automatic logic obs_ready(input int n);
      return (n == 8) ? bus8.in_ready : bus3.in_ready;
   endfunction
   function automatic logic [31:0] obs_char(input int n);
      return (n == 8) ? bus8.out_character : {20'd0, bus3.out_character};
   endfunction
   function automatic logic [39:0] obs_wt(input int n);
      return (n == 8) ? bus8.out_weight : {25'd0, bus3.out_weight};
   endfunction

   task automatic drive(input int n, input logic v, input logic m,
                        input logic [31:0] c, input logic [39:0] w);
      if (n == 8) begin
         bus8.in_valid = v; bus8.in_mode = m; bus8.in_character = c; bus8.in_weight = w;
      end else begin
         bus3.in_valid = v; bus3.in_mode = m;
         bus3.in_character = c[11:0]; bus3.in_weight = w[14:0];
      end
   endtask

   task automatic set_out_ready(input int n, input logic v);
      if (n == 8) bus8.out_ready = v;
      else        bus3.out_ready = v;
   endtask

   // Reference: slot order is element n-1..0, then a stable sort by weight
   task automatic model(input int n, input logic [31:0] c, input logic [39:0] w, input logic m,
                        output logic [31:0] ec, output logic [39:0] ew);
      int idx[8];
      int j, t;
      logic [4:0] wa, wb;
      for (int s = 0; s < n; s++) idx[s] = n - 1 - s;
      for (int i = 1; i < n; i++) begin
         j = i;
         while (j > 0) begin
            wa = w[idx[j-1]*5 +: 5];
            wb = w[idx[j]*5 +: 5];
            if (m ? (wa > wb) : (wa < wb)) begin
               t = idx[j-1]; idx[j-1] = idx[j]; idx[j] = t;
               j--;
            end else begin
               j = 0;
            end
         end
      end
      ec = '0;
      ew = '0;
      for (int s = 0; s < n; s++) begin
         ec[(n-1-s)*4 +: 4] = c[idx[s]*4 +: 4];
         ew[(n-1-s)*5 +: 5] = w[idx[s]*5 +: 5];
      end
   endtask

   // One bundle end to end. preloaded: in_valid already high in IDLE.
   // bp: present the next bundle while the result is held.
   task automatic run_bundle(input int n, input logic [31:0] c, input logic [39:0] w,
                             input logic m, input int hold, input bit preloaded, input bit bp,
                             input logic [31:0] nc, input logic [39:0] nw, input logic nm);
      logic [31:0] ec;
      logic [39:0] ew;
      int lat;
      model(n, c, w, m, ec, ew);
      if (!preloaded) begin
         @(negedge clk);
         drive(n, 1'b1, m, c, w);
      end
      check("in_ready_idle", obs_ready(n), 1);
      @(posedge clk); #1;
      drive(n, 1'b0, m, c, w);
      check("in_ready_busy", obs_ready(n), 0);
      lat = 0;
      while (obs_valid(n) !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, n);
      check("out_char", obs_char(n), ec);
      check("out_weight", obs_wt(n), ew);
      if (bp) drive(n, 1'b1, nm, nc, nw);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_char", obs_char(n), ec);
         check("hold_weight", obs_wt(n), ew);
         check("hold_valid", obs_valid(n), 1);
         check("hold_in_ready", obs_ready(n), 0);
      end
      set_out_ready(n, 1'b1);
      @(posedge clk); #1;
      set_out_ready(n, 1'b0);
      check("release_valid", obs_valid(n), 0);
      check("release_in_ready", obs_ready(n), 1);
   endtask

   logic [31:0] c8, rc, c3;
   logic [39:0] w8, weq, rw, w3;
   int          wl[8] = '{5, 3, 5, 1, 0, 7, 2, 5};
   int          n;

   initial begin
      rst_n = 1'b0;
      drive(8, 1'b0, 1'b0, '0, '0);
      drive(3, 1'b0, 1'b0, '0, '0);
      set_out_ready(8, 1'b0);
      set_out_ready(3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", obs_ready(8), 1);
      check("rst_out_valid", obs_valid(8), 0);
      check("rst_char", obs_char(8), 0);
      check("rst_weight", obs_wt(8), 0);
      check("rst3_in_ready", obs_ready(3), 1);
      @(negedge clk) rst_n = 1'b1;

      // Directed pattern from the reference example
      c8 = 32'h7654_3210;
      for (int i = 0; i < 8; i++) w8[i*5 +: 5] = 5'(wl[i]);
      run_bundle(8, c8, w8, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      check("tp_desc_char", obs_char(8), 32'h5720_1634);
      check("tp_desc_weight", obs_wt(8),
            {5'd7, 5'd5, 5'd5, 5'd5, 5'd3, 5'd2, 5'd1, 5'd0});
      run_bundle(8, c8, w8, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      check("tp_asc_char", obs_char(8), 32'h4361_7205);

      // All-equal weights: order must be untouched in both modes
      for (int i = 0; i < 8; i++) weq[i*5 +: 5] = 5'd9;
      run_bundle(8, c8, weq, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      check("tie_desc_char", obs_char(8), 32'h7654_3210);
      run_bundle(8, c8, weq, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      check("tie_asc_char", obs_char(8), 32'h7654_3210);

      // Back-pressure with a new bundle waiting, then accepted right after
      rc = $urandom;
      rw = {$urandom, $urandom};
      run_bundle(8, c8, w8, 1'b0, 5, 1'b0, 1'b1, rc, rw, 1'b1);
      run_bundle(8, rc, rw, 1'b1, 0, 1'b1, 1'b0, '0, '0, 1'b0);

      // Reset during phase 3
      @(negedge clk);
      drive(8, 1'b1, 1'b0, c8, w8);
      @(posedge clk); #1;
      drive(8, 1'b0, 1'b0, c8, w8);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", obs_valid(8), 0);
      check("midrst_in_ready", obs_ready(8), 1);
      check("midrst_char", obs_char(8), 0);
      check("midrst_weight", obs_wt(8), 0);
      @(negedge clk) rst_n = 1'b1;
      run_bundle(8, c8, w8, 1'b0, 1, 1'b0, 1'b0, '0, '0, 1'b0);
      check("post_rst_char", obs_char(8), 32'h5720_1634);

      // N=3: A,B,C with weights 1,9,4, descending
      c3 = 32'h0000_0CBA;
      w3 = {25'd0, 5'd4, 5'd9, 5'd1};
      run_bundle(3, c3, w3, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
      check("n3_char", obs_char(3), 32'h0000_0BCA);

      // Random bundles on both sizes, small weight range to force ties
      for (int it = 0; it < 24; it++) begin
         n  = ($urandom_range(0, 2) == 0) ? 3 : 8;
         rc = $urandom;
         for (int i = 0; i < 8; i++)
            rw[i*5 +: 5] = (it % 2 == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
         if (n == 3) begin
            rc = rc & 32'h0000_0FFF;
            rw = rw & 40'h00_0000_7FFF;
         end
         run_bundle(n, rc, rw, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    1'b0, 1'b0, '0, '0, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
